// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, instruction
// field positions and the opcodes the control unit also decodes.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_LSB    = 0;

  localparam logic [5:0] OPC_RTYPE = 6'd0;
  localparam logic [5:0] OPC_ADDI  = 6'b000010;

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of the fetch unit's memory port, redirect input and decoded-instruction
// output; master is the fetch unit, slave is memory plus downstream consumer.
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  // Memory: imem_req pulses for one cycle with imem_addr; imem_valid/imem_rdata
  // return exactly one response per request. Downstream: an instruction moves
  // on an edge where inst_valid && inst_ready && !branch_taken; while
  // inst_valid is high and no transfer happens, every field stays stable.
  logic              imem_req;
  logic [31:0]       imem_addr;
  logic              imem_valid;
  logic [31:0]       imem_rdata;
  logic              branch_taken;
  logic [31:0]       branch_target;
  logic              inst_valid;
  logic              inst_ready;
  logic [5:0]        opcode;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [5:0]        funct;
  logic [15:0]       imm;
  logic [31:0]       pc_out;
  logic [31:0]       pc_plus4;
  fetch_state_e      dbg_state;

  modport master (
    output imem_req, imem_addr,
    input  imem_valid, imem_rdata,
    input  branch_taken, branch_target,
    output inst_valid,
    input  inst_ready,
    output opcode, rs, rt, rd, shamt, funct, imm, pc_out, pc_plus4,
    output dbg_state
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_valid, imem_rdata,
    output branch_taken, branch_target,
    input  inst_valid,
    output inst_ready,
    input  opcode, rs, rt, rd, shamt, funct, imm, pc_out, pc_plus4,
    input  dbg_state
  );

endinterface

// File: rtl/instr_fetch_inst_fields.sv
// Pure slicing of a 32-bit instruction word into its fields; no sign extension.
module instr_fetch_inst_fields
  import instr_fetch_pkg::*;
(
  input  logic [31:0] ir_i,
  output logic [5:0]  opcode_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  shamt_o,
  output logic [5:0]  funct_o,
  output logic [15:0] imm_o
);

  assign opcode_o = ir_i[OPCODE_LSB +: 6];
  assign rs_o     = ir_i[RS_LSB +: 5];
  assign rt_o     = ir_i[RT_LSB +: 5];
  assign rd_o     = ir_i[RD_LSB +: 5];
  assign shamt_o  = ir_i[SHAMT_LSB +: 5];
  assign funct_o  = ir_i[FUNCT_LSB +: 6];
  assign imm_o    = ir_i[IMM_LSB +: 16];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, keeps at most one memory read in flight,
// holds the returned word in IR and offers its fields downstream.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic         clk,
  input logic         rst,
  instr_fetch_if.master bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ir_q, ir_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic         inst_valid_q, inst_valid_d;
  logic [1:0]   unused_target_lsbs;

  assign unused_target_lsbs = bus.branch_target[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_REQ;
      pc_q         <= {RESET_PC[31:2], 2'b00};
      ir_q         <= '0;
      pc_out_q     <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      pc_out_q     <= pc_out_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    pc_out_d = pc_out_q;
    case (state_q)
      // A redirect here leaves the just-issued read outstanding, so drain it.
      ST_REQ:  state_d = bus.branch_taken ? ST_DROP : ST_WAIT;
      ST_WAIT: begin
        if (bus.branch_taken) begin
          state_d = bus.imem_valid ? ST_REQ : ST_DROP;
        end else if (bus.imem_valid) begin
          ir_d     = bus.imem_rdata;
          pc_out_d = pc_q;
          state_d  = ST_HOLD;
        end
      end
      ST_DROP: begin
        if (bus.imem_valid) state_d = ST_REQ;
      end
      ST_HOLD: begin
        if (bus.branch_taken) begin
          state_d = ST_REQ;
        end else if (bus.inst_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
    if (bus.branch_taken) pc_d = {bus.branch_target[31:2], 2'b00};
    inst_valid_d = (state_d == ST_HOLD);
  end

  logic [5:0]  opcode_w;
  logic [4:0]  rs_w, rt_w, rd_w, shamt_w;
  logic [5:0]  funct_w;
  logic [15:0] imm_w;

  instr_fetch_inst_fields u_fields (
    .ir_i     (ir_q),
    .opcode_o (opcode_w),
    .rs_o     (rs_w),
    .rt_o     (rt_w),
    .rd_o     (rd_w),
    .shamt_o  (shamt_w),
    .funct_o  (funct_w),
    .imm_o    (imm_w)
  );

  // The request is gated by rst so nothing is issued while reset is held.
  assign bus.imem_req   = (state_q == ST_REQ) && !rst;
  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.opcode     = opcode_w;
  assign bus.rs         = rs_w;
  assign bus.rt         = rt_w;
  assign bus.rd         = rd_w;
  assign bus.shamt      = shamt_w;
  assign bus.funct      = funct_w;
  assign bus.imm        = imm_w;
  assign bus.pc_out     = pc_out_q;
  assign bus.pc_plus4   = pc_out_q + 32'd4;
  assign bus.dbg_state  = state_q;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit that produces the instruction stream consumed by the main control unit and the datapath. It owns the PC, issues one word-aligned read at a time to instruction memory, and captures the returned word in an instruction register. It presents the decoded fields (opcode, rs, rt, rd, shamt, funct, imm) downstream under a valid/ready handshake. Branch redirects flush in-flight work and restart fetch at the target.

## Interface
Clock is `clk`. Reset is `rst`, synchronous and active-high.

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset. Must be word-aligned.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous active-high reset.
- `imem_req`  out  1  read request, high for exactly one cycle per fetch.
- `imem_addr`  out  32  read address, valid while `imem_req`=1, bits [1:0] always 0.
- `imem_valid`  in  1  read response strobe, one cycle, ≥1 cycle after `imem_req`.
- `imem_rdata`  in  32  instruction word, valid with `imem_valid`.
- `branch_taken`  in  1  redirect strobe.
- `branch_target`  in  32  redirect PC. Bits [1:0] are forced to 0.
- `inst_valid`  out  1  instruction fields valid.
- `inst_ready`  in  1  downstream accepts the current instruction.
- `opcode`  out  6  IR[31:26], driven to the control unit `inst` input.
- `rs`  out  5  IR[25:21].
- `rt`  out  5  IR[20:16].
- `rd`  out  5  IR[15:11].
- `shamt`  out  5  IR[10:6].
- `funct`  out  6  IR[5:0].
- `imm`  out  16  IR[15:0].
- `pc_out`  out  32  address of the held instruction.
- `pc_plus4`  out  32  `pc_out`+4, mod 2^32.

## Operation
- States: REQ, WAIT, DROP, HOLD.
- REQ:
  - `imem_req`=1, `imem_addr`=PC.
  - Go to WAIT.
- WAIT, on `imem_valid`:
  - IR <= `imem_rdata`, `pc_out` <= PC.
  - Go to HOLD.
- HOLD: `inst_valid`=1.
  - If `inst_ready`: PC <= PC+4 (wraps 32'hFFFF_FFFC -> 0), go to REQ.
  - Otherwise: hold every output stable.
- Redirect (`branch_taken`=1). Redirect has priority over every other event in the same cycle. PC <= {`branch_target`[31:2],2'b00}, `inst_valid` <= 0. Next state by current state:
  - REQ -> WAIT is replaced by DROP, because the request issued this cycle is outstanding.
  - WAIT -> DROP; a response in the same cycle is discarded and the state goes to REQ instead.
  - DROP -> stays in DROP with the updated target; a response in the same cycle is discarded and the state goes to REQ.
  - HOLD -> REQ; the held instruction is discarded even if `inst_ready`=1 that cycle.
- DROP, on `imem_valid`: discard the data, go to REQ. IR and `pc_out` are unchanged.
- At most one read outstanding, ever.
- `imem_valid` in REQ or HOLD is ignored. Memory never does this.
- Fields are pure slices of IR. No sign extension; that happens downstream.

## Timing
- Reset values: state=REQ, PC=`RESET_PC`, IR=0, `pc_out`=0, `inst_valid`=0, `imem_req`=0.
  - The first request is driven in the first cycle after `rst` deasserts.
  - `rst` mid-operation aborts everything. A response arriving after reset while in REQ is ignored.
- All outputs are registered, except:
  - `imem_req`/`imem_addr`, decoded from state and PC.
  - `pc_plus4`, an adder on `pc_out`.
- Latency with a 1-cycle memory and `inst_ready` tied high:
  - Cycle 0: REQ.
  - Cycle 1: `imem_valid` arrives.
  - Cycle 2: `inst_valid`=1.
  - Cycle 3: next REQ.
  - Throughput: 1 instruction per 3 cycles; each extra memory wait cycle adds 1.
- Transfer occurs on the edge where `inst_valid`&&`inst_ready`&&!`branch_taken`. `inst_valid` falls the next cycle.
- A redirect accepted in cycle N leads to:
  - REQ at target in cycle N+1 if no read was outstanding.
  - Otherwise REQ in the cycle after the stale response.

## Structure
- Shared package holds:
  - State encoding (2 bits).
  - Instruction field bit positions.
  - The opcode constants shared with the control unit: R-type 6'd0, ADDI 6'b000010.
- One sub-module is natural: `inst_fields`. It is purely combinational: 32-bit IR in, the seven slices out. The control unit's testbench reuses it.

## Test plan
- Reset, 1-cycle memory, ready high, memory words 0x0000_0020 and 0x0800_0005:
  - `imem_addr`=0 then 4.
  - `opcode`=0,`funct`=0x20 first; then `opcode`=2,`imm`=5.
  - `pc_out` 0 then 4; 3-cycle spacing.
- Backpressure: `inst_ready` low 5 cycles in HOLD:
  - Fields and `pc_out` stable.
  - No `imem_req`.
  - Next REQ 1 cycle after ready rises.
- Redirect in WAIT with 4-cycle memory, target 0x0000_0103:
  - The stale response is discarded and `inst_valid` stays 0.
  - Next `imem_addr`=0x0000_0100.
- Redirect in HOLD coincident with `inst_ready`=1:
  - The instruction is not counted as transferred.
  - Next `imem_addr`=target.
  - `inst_valid` is 0 the following cycle.
- Wrap-around: `RESET_PC`=32'hFFFF_FFFC. After one transfer, `imem_addr`=0.
- `rst` asserted during WAIT:
  - Next cycle all outputs are at reset values.
  - A late `imem_valid` is ignored.
  - Fetch restarts at `RESET_PC`.
